// File: rtl/fgp_packet_queue.sv
// fgp_packet_queue: packet-buffer queue controller.
// The write side packs fixed-length FGP frames into power-of-two partitions
// of the packet buffer RAM and commits each complete frame to a circular
// queue. The read side launches one transmission per committed frame and
// retires the frame when the transmitter reports completion.
module fgp_packet_queue #(
    parameter int RAM_SIZE  = 16384,
    parameter int FRAME_LEN = 772,
    // Derived sizes; not meant to be overridden.
    parameter int PART_LEN  = 2 ** $clog2(FRAME_LEN),
    parameter int QUEUE_LEN = RAM_SIZE / PART_LEN,
    parameter int AW        = $clog2(RAM_SIZE),
    parameter int QW        = $clog2(QUEUE_LEN),
    parameter int CW        = $clog2(PART_LEN)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          abort,
    input  logic          inclk,
    input  logic [7:0]    in,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [7:0]    ram_win,
    output logic          tx_start,
    output logic [AW-1:0] tx_read_start,
    input  logic          tx_done,
    output logic          tx_busy,
    output logic [QW-1:0] count,
    output logic          drop
);

    // Byte counter needs at least one bit even for single-byte frames.
    localparam int CWX = (CW > 0) ? CW : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // State registers
    logic [QW-1:0]  head_q,   head_d;
    logic [QW-1:0]  tail_q,   tail_d;
    logic [CWX-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]     state_q,  state_d;

    // Registered outputs
    logic           ram_we_q,        ram_we_d;
    logic [AW-1:0]  ram_waddr_q,     ram_waddr_d;
    logic [7:0]     ram_win_q,       ram_win_d;
    logic           tx_start_q,      tx_start_d;
    logic [AW-1:0]  tx_read_start_q, tx_read_start_d;
    logic           tx_busy_q,       tx_busy_d;
    logic [QW-1:0]  count_q,         count_d;
    logic           drop_q,          drop_d;

    logic last_byte_s;
    logic full_s;

    // Frame-end and queue-full detection; full uses the head as registered now.
    always_comb begin
        last_byte_s = (wr_cnt_q == CWX'(FRAME_LEN - 1));
        full_s      = ((tail_q + QW'(1)) == head_q);
    end

    // Write path: stage each accepted byte into the tail partition and commit on frame end.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        tail_d      = tail_q;
        drop_d      = 1'b0;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_win_d   = ram_win_q;
        if (abort) begin
            // Abort wins over a coincident byte; the partial frame is discarded.
            wr_cnt_d = {CWX{1'b0}};
        end else if (inclk) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = (AW'(tail_q) << CW) | AW'(wr_cnt_q);
            ram_win_d   = in;
            if (last_byte_s) begin
                wr_cnt_d = {CWX{1'b0}};
                if (!full_s) begin
                    tail_d = tail_q + QW'(1);
                end else begin
                    // Queue full: keep the tail so the next frame reuses the slot.
                    drop_d = 1'b1;
                end
            end else begin
                wr_cnt_d = wr_cnt_q + CWX'(1);
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // Read FSM: launch one transmission per committed frame, retire it on tx_done.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        case (state_q)
            ST_IDLE: begin
                if (head_q != tail_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // tx_done is ignored while the start pulse is out.
                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (tx_done) begin
                    head_d  = head_q + QW'(1);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so registered outputs track the state registers.
    always_comb begin
        tx_start_d      = (state_d == ST_START);
        tx_busy_d       = (state_d == ST_START) || (state_d == ST_ACTIVE);
        count_d         = tail_d - head_d;
        tx_read_start_d = AW'(head_d) << CW;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q          <= {QW{1'b0}};
            tail_q          <= {QW{1'b0}};
            wr_cnt_q        <= {CWX{1'b0}};
            state_q         <= ST_IDLE;
            ram_we_q        <= 1'b0;
            ram_waddr_q     <= {AW{1'b0}};
            ram_win_q       <= 8'h00;
            tx_start_q      <= 1'b0;
            tx_read_start_q <= {AW{1'b0}};
            tx_busy_q       <= 1'b0;
            count_q         <= {QW{1'b0}};
            drop_q          <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            wr_cnt_q        <= wr_cnt_d;
            state_q         <= state_d;
            ram_we_q        <= ram_we_d;
            ram_waddr_q     <= ram_waddr_d;
            ram_win_q       <= ram_win_d;
            tx_start_q      <= tx_start_d;
            tx_read_start_q <= tx_read_start_d;
            tx_busy_q       <= tx_busy_d;
            count_q         <= count_d;
            drop_q          <= drop_d;
        end
    end

    assign ram_we        = ram_we_q;
    assign ram_waddr     = ram_waddr_q;
    assign ram_win       = ram_win_q;
    assign tx_start      = tx_start_q;
    assign tx_read_start = tx_read_start_q;
    assign tx_busy       = tx_busy_q;
    assign count         = count_q;
    assign drop          = drop_q;

endmodule

// File: tb/tb_fgp_packet_queue.sv
// Directed testbench for fgp_packet_queue with FRAME_LEN=4, RAM_SIZE=32
// (four-byte partitions, eight queue slots).
module tb_fgp_packet_queue;

    logic       clk     = 1'b0;
    logic       rstn    = 1'b0;
    logic       abort   = 1'b0;
    logic       inclk   = 1'b0;
    logic [7:0] in_b    = 8'h00;
    logic       tx_done = 1'b0;

    logic       ram_we;
    logic [4:0] ram_waddr;
    logic [7:0] ram_win;
    logic       tx_start;
    logic [4:0] tx_read_start;
    logic       tx_busy;
    logic [2:0] count;
    logic       drop;

    fgp_packet_queue #(.RAM_SIZE(32), .FRAME_LEN(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .abort         (abort),
        .inclk         (inclk),
        .in            (in_b),
        .ram_we        (ram_we),
        .ram_waddr     (ram_waddr),
        .ram_win       (ram_win),
        .tx_start      (tx_start),
        .tx_read_start (tx_read_start),
        .tx_done       (tx_done),
        .tx_busy       (tx_busy),
        .count         (count),
        .drop          (drop)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Event log filled on the falling edge
    logic [12:0] wlog[$];
    int starts   = 0;
    int drops    = 0;
    int cyc      = 0;
    int done_cyc = -1;
    int min_gap  = 1000;
    bit ee_seen  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (ram_we) begin
                wlog.push_back({ram_waddr, ram_win});
                if (ram_win == 8'hEE) ee_seen = 1'b1;
            end
            if (tx_start) begin
                starts = starts + 1;
                if (done_cyc >= 0 && (cyc - done_cyc) < min_gap) min_gap = cyc - done_cyc;
            end
            if (drop) drops = drops + 1;
            if (tx_done) done_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        inclk = 1'b1;
        in_b  = b;
        tick();
        inclk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int b = 0; b < 4; b++) send_byte(base + 8'(b));
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        inclk   = 1'b0;
        abort   = 1'b0;
        tx_done = 1'b0;
        in_b    = 8'h00;
        tick();
        tick();
        rstn = 1'b1;
        wlog.delete();
        starts   = 0;
        drops    = 0;
        done_cyc = -1;
        min_gap  = 1000;
        ee_seen  = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, ram_we, ram_waddr, ram_win, tx_start, tx_read_start, tx_busy, count, drop};
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sb;
        // ---------------- Reset state and single frame ----------------
        tick();
        check_val("rst_outputs", all_outs(), 32'd0);
        do_reset();
        send_byte(8'h10);
        check_val("t1_we", {31'd0, ram_we}, 32'd1);
        check_val("t1_win0", {24'd0, ram_win}, 32'h10);
        check_val("t1_waddr0", {27'd0, ram_waddr}, 32'd0);
        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'h13);
        check_val("t1_count", {29'd0, count}, 32'd1);
        check_val("t1_no_start_yet", {31'd0, tx_start}, 32'd0);
        tick();
        check_val("t1_start", {31'd0, tx_start}, 32'd1);
        check_val("t1_rdstart", {27'd0, tx_read_start}, 32'd0);
        check_val("t1_busy", {31'd0, tx_busy}, 32'd1);
        tick();
        check_val("t1_start_pulse", {31'd0, tx_start}, 32'd0);
        check_val("t1_wlog_n", wlog.size(), 32'd4);
        check_val("t1_wlog0", {19'd0, wlog[0]}, {19'd0, 5'd0, 8'h10});
        check_val("t1_wlog3", {19'd0, wlog[3]}, {19'd0, 5'd3, 8'h13});
        repeat (18) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_val("t1_count_done", {29'd0, count}, 32'd0);
        check_val("t1_rdstart_head1", {27'd0, tx_read_start}, 32'd4);
        check_val("t1_busy_done", {31'd0, tx_busy}, 32'd0);

        // ---------------- Fill and drop ----------------
        do_reset();
        for (int f = 0; f < 9; f++) begin
            send_frame(8'(f * 16));
            check_val($sformatf("t2_drop_f%0d", f), {31'd0, drop}, (f >= 7) ? 32'd1 : 32'd0);
        end
        tick();
        check_val("t2_count", {29'd0, count}, 32'd7);
        check_val("t2_drops", drops, 32'd2);
        check_val("t2_starts", starts, 32'd1);
        check_val("t2_wlog_n", wlog.size(), 32'd36);
        check_val("t2_wlog27", {19'd0, wlog[27]}, {19'd0, 5'd27, 8'h63});
        check_val("t2_wlog28", {19'd0, wlog[28]}, {19'd0, 5'd28, 8'h70});
        check_val("t2_wlog35", {19'd0, wlog[35]}, {19'd0, 5'd31, 8'h83});

        // ---------------- Abort mid-frame ----------------
        do_reset();
        send_byte(8'hA0);
        send_byte(8'hA1);
        abort = 1'b1;
        inclk = 1'b1;
        in_b  = 8'hEE;
        tick();
        abort = 1'b0;
        inclk = 1'b0;
        check_val("t3_no_we", {31'd0, ram_we}, 32'd0);
        send_frame(8'hB0);
        tick();
        check_val("t3_wlog_n", wlog.size(), 32'd6);
        check_val("t3_wlog1", {19'd0, wlog[1]}, {19'd0, 5'd1, 8'hA1});
        check_val("t3_wlog2", {19'd0, wlog[2]}, {19'd0, 5'd0, 8'hB0});
        check_val("t3_wlog5", {19'd0, wlog[5]}, {19'd0, 5'd3, 8'hB3});
        check_val("t3_ee", {31'd0, ee_seen}, 32'd0);
        check_val("t3_count", {29'd0, count}, 32'd1);

        // ---------------- Coincident commit and retire ----------------
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(8'(8'h40 + f * 16));
        repeat (3) tick();
        check_val("t4_count3", {29'd0, count}, 32'd3);
        check_val("t4_busy", {31'd0, tx_busy}, 32'd1);
        send_byte(8'h70);
        send_byte(8'h71);
        send_byte(8'h72);
        inclk   = 1'b1;
        in_b    = 8'h73;
        tx_done = 1'b1;
        tick();
        inclk   = 1'b0;
        tx_done = 1'b0;
        check_val("t4_count_same", {29'd0, count}, 32'd3);
        check_val("t4_head1", {27'd0, tx_read_start}, 32'd4);
        check_val("t4_lastaddr", {27'd0, ram_waddr}, 32'd15);
        check_val("t4_no_drop", {31'd0, drop}, 32'd0);
        tick();
        check_val("t4_restart", {31'd0, tx_start}, 32'd1);
        check_val("t4_drops", drops, 32'd0);

        // ---------------- Wrap-around ----------------
        do_reset();
        send_frame(8'h00);
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 12 && !tx_start; k++) tick();
            check_val($sformatf("t5_start%0d", i), {31'd0, tx_start}, 32'd1);
            check_val($sformatf("t5_addr%0d", i), {27'd0, tx_read_start}, 32'((i % 8) * 4));
            if (i < 19) send_frame(8'((i + 1) * 4));
            else tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        repeat (4) tick();
        check_val("t5_starts", starts, 32'd20);
        check_val("t5_drops", drops, 32'd0);
        check_val("t5_count", {29'd0, count}, 32'd0);
        check_val("t5_gap_ok", {31'd0, (min_gap >= 2)}, 32'd1);

        // ---------------- Asynchronous reset while ACTIVE ----------------
        do_reset();
        send_frame(8'h20);
        send_frame(8'h30);
        repeat (3) tick();
        check_val("t6_count2", {29'd0, count}, 32'd2);
        check_val("t6_busy", {31'd0, tx_busy}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("t6_async_zero", all_outs(), 32'd0);
        #1;
        rstn = 1'b1;
        sb = starts;
        repeat (6) tick();
        check_val("t6_no_start", starts, sb);
        check_val("t6_idle", {31'd0, tx_busy}, 32'd0);
        check_val("t6_count0", {29'd0, count}, 32'd0);
        send_frame(8'h50);
        repeat (2) tick();
        check_val("t6_new_start", starts, sb + 1);
        check_val("t6_rdstart", {27'd0, tx_read_start}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fgp_packet_queue.md
Name: fgp_packet_queue

Overview:
- Packet-buffer queue controller between the encrypted FGP byte stream (fgp_rx offset byte + AES encryptor output) and the Ethernet transmit path (stream_from_memory + eth_tx).
- Write side: packs fixed-length FGP frames into power-of-two partitions of the packet buffer RAM and commits each complete frame to a circular queue.
- Read side: launches one transmission per committed frame and retires the frame on tx_done.

Parameters:
- RAM_SIZE, 16384: packet buffer size in bytes; must be a power of two.
- FRAME_LEN, 772: bytes per FGP frame; 1 <= FRAME_LEN <= RAM_SIZE/2.
- Derived PART_LEN = 2**clog2(FRAME_LEN), the partition size.
- Derived QUEUE_LEN = RAM_SIZE/PART_LEN, the number of slots. Usable capacity is QUEUE_LEN-1.
- Derived AW = clog2(RAM_SIZE), QW = clog2(QUEUE_LEN), CW = clog2(PART_LEN).

Ports:
- clk  in  1  system clock (50 MHz)
- rstn  in  1  reset, asynchronous, active-low
- abort  in  1  synchronous; discard the partially received frame
- inclk  in  1  input byte strobe
- in  in  8  input byte
- ram_we  out  1  packet buffer write enable
- ram_waddr  out  AW  write address, {tail, wr_cnt}
- ram_win  out  8  write data
- tx_start  out  1  one-cycle pulse that starts a transmission
- tx_read_start  out  AW  {head, CW zeros}; stable from tx_start until the frame is retired
- tx_done  in  1  transmission complete pulse
- tx_busy  out  1  high in the START and ACTIVE states
- count  out  QW  committed, untransmitted frames: (tail - head) mod QUEUE_LEN
- drop  out  1  one-cycle pulse when a completed frame is discarded because the queue is full

Behaviour:
- Reset (rstn low, asynchronous):
  - head = tail = wr_cnt = 0 and state = IDLE.
  - All outputs are 0: ram_we, ram_waddr, ram_win, tx_start, tx_busy, drop, count, tx_read_start.
- Write path (registered, latency 1):
  - On inclk && !abort: next cycle ram_we = 1, ram_waddr = {tail, wr_cnt}, ram_win = in. Otherwise ram_we = 0; waddr and win hold their values.
  - Each accepted byte increments wr_cnt.
  - When wr_cnt == FRAME_LEN-1 on an accepted byte, wr_cnt returns to 0 and the frame completes:
    - If tail+1 != head (head as registered that cycle), tail increments (wraps mod QUEUE_LEN).
    - Otherwise tail is unchanged, drop pulses the next cycle, and the next frame overwrites the same uncommitted slot.
  - The full check uses the pre-update head. A frame completing in the same cycle that head advances is still dropped when the queue was full.
  - abort: wr_cnt = 0, no write, no commit. abort has priority over a coincident inclk, and that byte is lost. abort does not affect the read side.
- Read FSM:
  - IDLE:
    - If head != tail, go to START.
  - START (one cycle):
    - tx_start = 1 and tx_busy = 1.
    - Go to ACTIVE.
    - tx_done in this state is ignored.
  - ACTIVE:
    - tx_busy = 1.
    - On tx_done: head increments (wraps), go to IDLE.
    - A new frame starts no earlier than 2 cycles after tx_done.
- Simultaneous commit and retire: both pointers update in the same cycle; count reflects both on the next cycle.
- Wrap-around: pointer arithmetic is QW bits and wraps naturally; wr_cnt never exceeds FRAME_LEN-1.
- Only the tail slot is ever written; slots from head to tail-1 are never written.

Test Plan:
Use FRAME_LEN=4, RAM_SIZE=32 (PART_LEN=4, QUEUE_LEN=8).
- Single frame: release rstn and send bytes 0x10..0x13.
  -> Writes land at addresses 0..3 with 0x10..0x13.
  -> count=1; tx_start pulses with tx_read_start=0.
  -> tx_done after 20 cycles gives head=1 and count=0.
- Fill and drop: hold tx_done low after the first start and send 9 frames.
  -> count saturates at 7.
  -> The 8th and 9th frames each pulse drop and are written to addresses 28..31; tail stays 7.
- Abort mid-frame: send 2 bytes, assert abort with inclk high, then send 4 bytes.
  -> The 4 bytes are written to {tail,0..3}; the aborted byte is not written; exactly one commit.
- Coincident commit and retire: with count=3 and ACTIVE, deliver the last byte of a frame in the same cycle as tx_done.
  -> head+1 and tail+1; count stays 3; no drop.
- Wrap-around: stream 20 frames with prompt tx_done.
  -> tx_read_start sequence 0,4,...,28,0,...; no drop.
  -> 20 tx_start pulses, each separated by at least 2 cycles after tx_done.
- Asynchronous reset in ACTIVE with count=2: pulse rstn low between clock edges.
  -> All outputs are 0 immediately; after release, no tx_start until a new frame commits.
